// File: rtl/rr_pkg.sv
// Shared constants, types and helpers for the round-robin requester slice.
// Latency: none (package only).
// Backpressure: not applicable.
package rr_pkg;
   localparam int REQS_DEF  = 4;
   localparam int CNT_W_DEF = 4;
   localparam int MAX_REQS  = 16;

   // Pending-job counter at the default width.
   typedef logic [CNT_W_DEF-1:0] pend_t;

   // True when the vector has at most one bit set.
   function automatic logic onehot0(input logic [MAX_REQS-1:0] v);
      return (v & (v - 16'd1)) == 16'd0;
   endfunction
endpackage

// File: rtl/rr_req_slot.sv
// One client: pending-job counter, done/drop pulses, optional wait counter (RR_REQUESTER_STARVE_CHECK_EN).
// Latency: req is combinational from the counter; done/drop/starve are registered, one cycle after the edge.
// Backpressure: a job arriving while the counter is full and no grant is taken is dropped and flagged.
module rr_req_slot #(
   parameter int CNT_W    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic job,
   input  logic grant,
   output logic req,
   output logic done,
   output logic drop,
   output logic starve
);
   logic [CNT_W-1:0] pend_q;
   logic             accept;
   logic             full;

   assign req    = (pend_q != '0);
   assign accept = grant & req;
   assign full   = &pend_q;

   // Pending counter: a job and a grant in the same cycle cancel, so nothing wraps or drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         done   <= 1'b0;
         drop   <= 1'b0;
      end else begin
         done <= accept;
         drop <= job & ~accept & full;
         if (job && !accept && !full)
            pend_q <= pend_q + CNT_W'(1);
         else if (accept && !job)
            pend_q <= pend_q - CNT_W'(1);
      end
   end

`ifdef RR_REQUESTER_STARVE_CHECK_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              starve_q;

   // Wait counter: counts ungranted request cycles, saturates at MAX_WAIT, sets a sticky flag on arrival.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         starve_q <= 1'b0;
      end else if (!req || accept) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
         if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
            starve_q <= 1'b1;
      end
   end

   assign starve = starve_q;
`else
   logic unused_cfg;
   assign unused_cfg = (MAX_WAIT > 0);
   assign starve     = 1'b0;
`endif
endmodule

// File: rtl/rr_requester.sv
// Per-client job counting in front of an external arbiter, with sticky protocol checking; optional starvation check via RR_REQUESTER_STARVE_CHECK_EN.
// Latency: reqs_o combinational from registered counters; done_o/drop_o/proto_err_o/starve_o one cycle after the edge.
// Backpressure: jobs beyond counter capacity are dropped with a drop_o pulse; requests persist until granted.
module rr_requester
   import rr_pkg::*;
#(
   parameter int REQS     = REQS_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int MAX_WAIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [REQS-1:0] job_i,
   output logic [REQS-1:0] reqs_o,
   input  logic [REQS-1:0] grants_i,
   input  logic            any_grant_i,
   output logic [REQS-1:0] done_o,
   output logic [REQS-1:0] drop_o,
   output logic            proto_err_o,
   output logic [REQS-1:0] starve_o
);
   logic proto_bad;

   for (genvar k = 0; k < REQS; k++) begin : g_slot
      rr_req_slot #(
         .CNT_W    (CNT_W),
         .MAX_WAIT (MAX_WAIT)
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .job    (job_i[k]),
         .grant  (grants_i[k]),
         .req    (reqs_o[k]),
         .done   (done_o[k]),
         .drop   (drop_o[k]),
         .starve (starve_o[k])
      );
   end

   // Arbiter contract: at most one winner, only requesters win, flag matches, someone wins when anyone asks.
   always_comb begin
      proto_bad = 1'b0;
      if (!onehot0(MAX_REQS'(grants_i)))        proto_bad = 1'b1;
      if ((grants_i & ~reqs_o) != '0)           proto_bad = 1'b1;
      if (any_grant_i != (|grants_i))           proto_bad = 1'b1;
      if ((reqs_o != '0) && (grants_i == '0))   proto_bad = 1'b1;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) proto_err_o <= 1'b0;
      else     proto_err_o <= proto_err_o | proto_bad;
   end
endmodule

// File: tb/tb_rr_requester.sv
module tb_rr_requester;
   import rr_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] job_i;
   logic [3:0] reqs_o;
   logic [3:0] grants_i;
   logic       any_grant_i;
   logic [3:0] done_o;
   logic [3:0] drop_o;
   logic       proto_err_o;
   logic [3:0] starve_o;

   int n_chk;
   int n_fail;

   rr_requester #(.REQS(4), .CNT_W(4), .MAX_WAIT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .job_i       (job_i),
      .reqs_o      (reqs_o),
      .grants_i    (grants_i),
      .any_grant_i (any_grant_i),
      .done_o      (done_o),
      .drop_o      (drop_o),
      .proto_err_o (proto_err_o),
      .starve_o    (starve_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] j, input logic [3:0] g);
      job_i       = j;
      grants_i    = g;
      any_grant_i = |g;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, 4'b0000);
      step();
      step();
      rst = 1'b0;
   endtask

   pend_t fill;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b0;
      drive(4'b0000, 4'b0000);

      // Reset state
      do_reset();
      chk("rst_reqs",   32'(reqs_o),      32'h0);
      chk("rst_done",   32'(done_o),      32'h0);
      chk("rst_drop",   32'(drop_o),      32'h0);
      chk("rst_proto",  32'(proto_err_o), 32'h0);
      chk("rst_starve", 32'(starve_o),    32'h0);

      // All clients request once, grants rotate 0..3
      drive(4'b1111, 4'b0000);
      step();
      chk("rr_reqs_all", 32'(reqs_o), 32'hF);
      for (int i = 0; i < 4; i++) begin
         drive(4'b0000, 4'(1 << i));
         step();
         chk("rr_done", 32'(done_o), 32'(1 << i));
         chk("rr_reqs", 32'(reqs_o), 32'(4'hF << (i + 1)) & 32'hF);
      end
      drive(4'b0000, 4'b0000);
      step();
      chk("rr_done_idle", 32'(done_o),      32'h0);
      chk("rr_proto",     32'(proto_err_o), 32'h0);

      // Client 2: 16 strobes without grants; 16th drops
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(4'b0100, 4'b0000);
         step();
         chk("fill_drop", 32'(drop_o), (i == 15) ? 32'h4 : 32'h0);
      end
      drive(4'b0000, 4'b0000);
      step();
      chk("fill_drop_after", 32'(drop_o), 32'h0);
      chk("fill_reqs",       32'(reqs_o), 32'h4);
      fill = '1;
      for (int i = 0; i < 15; i++) begin
         drive(4'b0000, 4'b0100);
         step();
         fill = fill - pend_t'(1);
         chk("drain2_done", 32'(done_o), 32'h4);
         chk("drain2_reqs", 32'(reqs_o), (fill != 0) ? 32'h4 : 32'h0);
      end

      // Client 1 full: job + grant together leaves it at 15
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(4'b0010, 4'b0000);
         step();
      end
      chk("full1_drop_pre", 32'(drop_o), 32'h0);
      drive(4'b0010, 4'b0010);
      step();
      chk("full1_done", 32'(done_o), 32'h2);
      chk("full1_drop", 32'(drop_o), 32'h0);
      for (int i = 0; i < 15; i++) begin
         drive(4'b0000, 4'b0010);
         step();
         chk("drain1_reqs", 32'(reqs_o), (i < 14) ? 32'h2 : 32'h0);
      end

      // Two grants at once: both accepted, error sticky
      do_reset();
      drive(4'b1100, 4'b0000);
      step();
      chk("multi_reqs_pre", 32'(reqs_o), 32'hC);
      drive(4'b0000, 4'b1100);
      step();
      chk("multi_proto", 32'(proto_err_o), 32'h1);
      chk("multi_done",  32'(done_o),      32'hC);
      chk("multi_reqs",  32'(reqs_o),      32'h0);
      drive(4'b0000, 4'b0000);
      step();
      step();
      step();
      chk("multi_sticky", 32'(proto_err_o), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("multi_cleared", 32'(proto_err_o), 32'h0);

      // Grant to a non-requesting client
      do_reset();
      drive(4'b0001, 4'b0000);
      step();
      drive(4'b0000, 4'b0010);
      step();
      chk("stray_proto", 32'(proto_err_o), 32'h1);
      chk("stray_done",  32'(done_o),      32'h0);
      chk("stray_reqs",  32'(reqs_o),      32'h1);

      // any_grant_i inconsistent with grants_i
      do_reset();
      drive(4'b0001, 4'b0000);
      step();
      job_i       = 4'b0000;
      grants_i    = 4'b0001;
      any_grant_i = 1'b0;
      step();
      chk("anyg_proto", 32'(proto_err_o), 32'h1);
      chk("anyg_done",  32'(done_o),      32'h1);

      // Client 3 starved for MAX_WAIT cycles, then reset mid-activity
      do_reset();
      drive(4'b1000, 4'b0000);
      step();
      drive(4'b0000, 4'b0000);
      for (int i = 0; i < 7; i++) step();
      chk("starve_pre", 32'(starve_o), 32'h0);
      step();
`ifdef RR_REQUESTER_STARVE_CHECK_EN
      chk("starve_set", 32'(starve_o), 32'h8);
`else
      chk("starve_off", 32'(starve_o), 32'h0);
`endif
      chk("starve_reqs", 32'(reqs_o), 32'h8);
      rst = 1'b1;
      drive(4'b1111, 4'b1111);
      step();
      rst = 1'b0;
      drive(4'b0000, 4'b0000);
      chk("midrst_reqs",   32'(reqs_o),      32'h0);
      chk("midrst_done",   32'(done_o),      32'h0);
      chk("midrst_drop",   32'(drop_o),      32'h0);
      chk("midrst_proto",  32'(proto_err_o), 32'h0);
      chk("midrst_starve", 32'(starve_o),    32'h0);
      step();
      chk("midrst_reqs2", 32'(reqs_o), 32'h0);
      chk("midrst_drop2", 32'(drop_o), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
